// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch buffer.
// The master side is the fetch/decode pipeline; the slave side is the buffer itself.
interface fetch_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_instr;
    logic          fetch_valid;
    logic          fetch_ready;
    logic          flush;
    logic          dec_valid;
    logic [31:0]   dec_pc;
    logic [31:0]   dec_instr;
    logic          dec_ready;
    logic [CW-1:0] count;
    logic          align_err;

    modport master (
        output fetch_pc, fetch_instr, fetch_valid, flush, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr, count, align_err
    );

    modport slave (
        input  fetch_pc, fetch_instr, fetch_valid, flush, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr, count, align_err
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a small FIFO of {pc, instr} pairs between the fetch and decode
// stages. Back-pressures the PC when full and drops everything on a redirect flush.
module fetch_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_buffer_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          align_err_q, align_err_d;

    logic          fetch_ready;
    logic          dec_valid;
    logic          push;
    logic          pop;

    // Ready/valid come only from registered occupancy, never from dec_ready.
    assign fetch_ready = (count_q != FullCount);
    assign dec_valid   = (count_q != '0);
    assign push        = bus.fetch_valid & fetch_ready & ~bus.flush;
    assign pop         = dec_valid & bus.dec_ready & ~bus.flush;

    assign bus.fetch_ready = fetch_ready;
    assign bus.dec_valid   = dec_valid;
    assign bus.dec_pc      = dec_valid ? pc_mem[rptr_q] : 32'h0;
    assign bus.dec_instr   = dec_valid ? instr_mem[rptr_q] : 32'h0;
    assign bus.count       = count_q;
    assign bus.align_err   = align_err_q;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        align_err_d = align_err_q;

        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Misaligned words are still stored; the flag just records that one went through.
        if (push && (bus.fetch_pc[1:0] != 2'b00)) begin
            align_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            align_err_q <= align_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr_q]    <= bus.fetch_pc;
            instr_mem[wptr_q] <= bus.fetch_instr;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer with hand-computed expectations.
module tb_fetch_buffer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fetch_buffer_if #(.DEPTH(4)) bus ();

    fetch_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.fetch_pc     = 32'h0;
        bus.fetch_instr  = 32'h0;
        bus.fetch_valid  = 1'b0;
        bus.flush        = 1'b0;
        bus.dec_ready    = 1'b0;

        // Reset state
        #2;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("rst_dec_pc", bus.dec_pc, 32'h0);
        check("rst_dec_instr", bus.dec_instr, 32'h0);
        check("rst_align_err", 32'(bus.align_err), 32'd0);
        step();
        reset = 1'b0;

        // Reset mid-operation
        bus.fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_pc    = 32'h3000 + 32'(4 * i);
            bus.fetch_instr = 32'h3401_0001 + 32'(i);
            step();
        end
        bus.fetch_valid = 1'b0;
        check("mid_count_pre", 32'(bus.count), 32'd3);
        check("mid_dec_pc_pre", bus.dec_pc, 32'h3000);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("mid_rst_dec_pc", bus.dec_pc, 32'h0);
        #1;
        reset = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h3000;
        bus.fetch_instr = 32'h3401_0001;
        step();
        bus.fetch_valid = 1'b0;
        check("post_rst_dec_pc", bus.dec_pc, 32'h3000);
        check("post_rst_dec_valid", 32'(bus.dec_valid), 32'd1);
        check("post_rst_count", 32'(bus.count), 32'd1);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        check("post_rst_pop_count", 32'(bus.count), 32'd0);

        // Fill with dec_ready low
        bus.fetch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.fetch_pc    = 32'h3000 + 32'(4 * i);
            bus.fetch_instr = 32'h3401_0001 + 32'(i);
            step();
        end
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        check("fill_dec_pc", bus.dec_pc, 32'h3000);
        check("fill_dec_instr", bus.dec_instr, 32'h3401_0001);
        bus.fetch_pc    = 32'h3010;
        bus.fetch_instr = 32'h3401_0005;
        step();
        check("full_drop_count", 32'(bus.count), 32'd4);

        // Drain; the first pop from full still offers 0x3010, which must be ignored
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_dec_pc", bus.dec_pc, 32'h3000 + 32'(4 * i));
            check("drain_dec_instr", bus.dec_instr, 32'h3401_0001 + 32'(i));
            step();
            bus.fetch_valid = 1'b0;
            if (i == 0) begin
                check("drain_pop_full_count", 32'(bus.count), 32'd3);
                check("drain_fetch_ready", 32'(bus.fetch_ready), 32'd1);
            end
        end
        check("drain_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("drain_dec_instr_nop", bus.dec_instr, 32'h0);
        check("drain_count", 32'(bus.count), 32'd0);

        // Concurrent push/pop at count=2 across pointer wrap
        bus.dec_ready   = 1'b0;
        bus.fetch_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.fetch_pc    = 32'h3100 + 32'(4 * i);
            bus.fetch_instr = 32'h2000_0000 + 32'(i);
            step();
        end
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.fetch_pc    = 32'h3108 + 32'(4 * i);
            bus.fetch_instr = 32'h2000_0002 + 32'(i);
            check("conc_dec_pc", bus.dec_pc, 32'h3100 + 32'(4 * i));
            step();
            check("conc_count", 32'(bus.count), 32'd2);
        end
        bus.dec_ready = 1'b0;
        check("conc_head_pc", bus.dec_pc, 32'h3118);
        check("conc_head_instr", bus.dec_instr, 32'h2000_0006);

        // Flush at count=3 with simultaneous push and pop
        bus.fetch_pc    = 32'h3120;
        bus.fetch_instr = 32'h2000_0008;
        step();
        check("pre_flush_count", 32'(bus.count), 32'd3);
        bus.flush       = 1'b1;
        bus.dec_ready   = 1'b1;
        bus.fetch_pc    = 32'h3020;
        bus.fetch_instr = 32'hdead_beef;
        step();
        bus.flush       = 1'b0;
        bus.dec_ready   = 1'b0;
        bus.fetch_valid = 1'b0;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("flush_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h3040;
        bus.fetch_instr = 32'h3401_0040;
        step();
        bus.fetch_valid = 1'b0;
        check("redirect_dec_pc", bus.dec_pc, 32'h3040);
        check("redirect_count", 32'(bus.count), 32'd1);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        check("redirect_pop_valid", 32'(bus.dec_valid), 32'd0);
        check("align_clear_before", 32'(bus.align_err), 32'd0);

        // Misaligned push sets the sticky flag; the word is still stored
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h3002;
        bus.fetch_instr = 32'h3401_0002;
        step();
        bus.fetch_valid = 1'b0;
        check("align_set", 32'(bus.align_err), 32'd1);
        check("align_word_stored", bus.dec_pc, 32'h3002);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("align_after_flush", 32'(bus.align_err), 32'd1);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h3004;
        step();
        bus.fetch_valid = 1'b0;
        check("align_after_push", 32'(bus.align_err), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("align_reset", 32'(bus.align_err), 32'd0);
        check("final_reset_count", 32'(bus.count), 32'd0);
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
